// File: rtl/final2_soc_nios2_qsys_0_mult_arbiter_if.sv
// Operand/response bundle between two requesters, the multiplier arbiter and the shared multiply cell.
// The DUT takes the slave view and the requesters plus the cell take the master view.
interface final2_soc_nios2_qsys_0_mult_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        resp0_valid;
    logic [31:0] resp0_result;
    logic        resp1_valid;
    logic [31:0] resp1_result;
    logic [31:0] A_mul_src1;
    logic [31:0] A_mul_src2;
    logic [31:0] A_mul_cell_result;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output resp0_valid, resp0_result,
        output resp1_valid, resp1_result,
        output A_mul_src1, A_mul_src2,
        input  A_mul_cell_result
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  resp0_valid, resp0_result,
        input  resp1_valid, resp1_result,
        input  A_mul_src1, A_mul_src2,
        output A_mul_cell_result
    );
endinterface

// File: rtl/final2_soc_nios2_qsys_0_mult_arbiter.sv
// Two-requester arbiter in front of a shared pipelined multiply cell, with an owner tag pipeline that routes results back.
// Defining MULT_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins); otherwise the arbiter is round-robin.
module final2_soc_nios2_qsys_0_mult_arbiter #(
    parameter int MUL_LATENCY = 1
) (
    input  logic clk,
    input  logic reset_n,
    final2_soc_nios2_qsys_0_mult_arbiter_if.slave bus
);

    if (MUL_LATENCY < 1 || MUL_LATENCY > 4) begin : g_bad_latency
        $error("MUL_LATENCY must be in 1..4");
    end

    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

    logic        grant0;
    logic        grant1;
    logic        xfer;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    tag_t [MUL_LATENCY:0] tag_q;
    tag_t        tag_out;
    logic        resp0_valid_q;
    logic        resp1_valid_q;
    logic [31:0] resp0_result_q;
    logic [31:0] resp1_result_q;

`ifndef MULT_ARB_FIXED_PRIO_EN
    logic last_grant;
`endif

    // NOTE: every variable an always_comb writes gets a default first, so no path can infer a latch.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef MULT_ARB_FIXED_PRIO_EN
        grant0 = bus.req0_valid;
`else
        grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
`endif
        grant1 = bus.req1_valid && !grant0;
    end

    // Gating with reset_n keeps ready low for the whole time reset is held, not just after the first edge.
    assign xfer           = (grant0 || grant1) && reset_n;
    assign bus.req0_ready = grant0 && reset_n;
    assign bus.req1_ready = grant1 && reset_n;

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src1_q <= '0;
            src2_q <= '0;
        end else if (xfer) begin
            src1_q <= grant0 ? bus.req0_a : bus.req1_a;
            src2_q <= grant0 ? bus.req0_b : bus.req1_b;
        end
    end

`ifndef MULT_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (xfer) begin
            last_grant <= grant1;
        end
    end
`endif

    // NOTE: the tag pipeline is reset, unlike a datapath memory, because a stale valid bit would emit a phantom response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_q <= '0;
        end else begin
            tag_q <= {tag_q[MUL_LATENCY-1:0], tag_t'{valid: xfer, owner: grant1}};
        end
    end

    // The last tag stage lines up with the cycle in which the cell presents this operation's product.
    assign tag_out = tag_q[MUL_LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp0_valid_q  <= 1'b0;
            resp1_valid_q  <= 1'b0;
            resp0_result_q <= '0;
            resp1_result_q <= '0;
        end else begin
            resp0_valid_q <= tag_out.valid && !tag_out.owner;
            resp1_valid_q <= tag_out.valid && tag_out.owner;
            if (tag_out.valid && !tag_out.owner) begin
                resp0_result_q <= bus.A_mul_cell_result;
            end
            if (tag_out.valid && tag_out.owner) begin
                resp1_result_q <= bus.A_mul_cell_result;
            end
        end
    end

    assign bus.A_mul_src1   = src1_q;
    assign bus.A_mul_src2   = src2_q;
    assign bus.resp0_valid  = resp0_valid_q;
    assign bus.resp1_valid  = resp1_valid_q;
    assign bus.resp0_result = resp0_result_q;
    assign bus.resp1_result = resp1_result_q;

endmodule

// File: tb/tb_final2_soc_nios2_qsys_0_mult_arbiter.sv
// Directed bench: one arbiter at MUL_LATENCY=1 and one at MUL_LATENCY=3, each behind a modelled multiply cell.
// Each step drives one cycle's inputs 1ns after the rising edge and checks outputs 1ns later.
module tb_final2_soc_nios2_qsys_0_mult_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    final2_soc_nios2_qsys_0_mult_arbiter_if bus ();
    final2_soc_nios2_qsys_0_mult_arbiter_if bus3 ();

    final2_soc_nios2_qsys_0_mult_arbiter #(.MUL_LATENCY(1)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    final2_soc_nios2_qsys_0_mult_arbiter #(.MUL_LATENCY(3)) u_dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3.slave)
    );

    always #5 clk = ~clk;

    // Multiply cells: one register stage for latency 1, three for latency 3.
    logic [31:0] cell1_q;
    logic [31:0] cell3_s1, cell3_s2, cell3_q;
    always @(posedge clk) begin
        cell1_q  <= bus.A_mul_src1 * bus.A_mul_src2;
        cell3_s1 <= bus3.A_mul_src1 * bus3.A_mul_src2;
        cell3_s2 <= cell3_s1;
        cell3_q  <= cell3_s2;
    end
    assign bus.A_mul_cell_result  = cell1_q;
    assign bus3.A_mul_cell_result = cell3_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1);
        bus.req0_valid = v0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req1_valid = v1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
    endtask

    // Drive this cycle's inputs, then check ready and response outputs of the latency-1 DUT.
    task automatic apply(input string name,
                         input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic er0, input logic er1,
                         input logic ev0, input logic [31:0] e0,
                         input logic ev1, input logic [31:0] e1);
        drive(v0, a0, b0, v1, a1, b1);
        #1;
        check({name, ".rdy0"}, 32'(bus.req0_ready), 32'(er0));
        check({name, ".rdy1"}, 32'(bus.req1_ready), 32'(er1));
        check({name, ".rv0"}, 32'(bus.resp0_valid), 32'(ev0));
        check({name, ".rv1"}, 32'(bus.resp1_valid), 32'(ev1));
        if (ev0) check({name, ".res0"}, bus.resp0_result, e0);
        if (ev1) check({name, ".res1"}, bus.resp1_result, e1);
    endtask

    task automatic step(input string name,
                        input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                        input logic er0, input logic er1,
                        input logic ev0, input logic [31:0] e0,
                        input logic ev1, input logic [31:0] e1);
        @(posedge clk);
        #1;
        apply(name, v0, a0, b0, v1, a1, b1, er0, er1, ev0, e0, ev1, e1);
    endtask

    // Requester-1-only cycle on the latency-3 DUT.
    task automatic step3(input string name, input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic er1, input logic ev1, input logic [31:0] e1);
        @(posedge clk);
        #1;
        bus3.req1_valid = v1;
        bus3.req1_a     = a1;
        bus3.req1_b     = b1;
        #1;
        check({name, ".rdy1"}, 32'(bus3.req1_ready), 32'(er1));
        check({name, ".rv0"}, 32'(bus3.resp0_valid), 32'd0);
        check({name, ".rv1"}, 32'(bus3.resp1_valid), 32'(ev1));
        if (ev1) check({name, ".res1"}, bus3.resp1_result, e1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".rdy0"}, 32'(bus.req0_ready), 32'd0);
        check({name, ".rdy1"}, 32'(bus.req1_ready), 32'd0);
        check({name, ".rv0"}, 32'(bus.resp0_valid), 32'd0);
        check({name, ".rv1"}, 32'(bus.resp1_valid), 32'd0);
        check({name, ".res0"}, bus.resp0_result, 32'd0);
        check({name, ".res1"}, bus.resp1_result, 32'd0);
        check({name, ".src1"}, bus.A_mul_src1, 32'd0);
        check({name, ".src2"}, bus.A_mul_src2, 32'd0);
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        bus3.req0_valid = 1'b0;
        bus3.req0_a     = '0;
        bus3.req0_b     = '0;
        bus3.req1_valid = 1'b0;
        bus3.req1_a     = '0;
        bus3.req1_b     = '0;

        // Reset held with both requesters valid: nothing may be granted.
        repeat (2) @(posedge clk);
        #1;
        drive(1'b1, 32'd3, 32'd7, 1'b1, 32'd4, 32'd4);
        #1;
        check_reset_outputs("rst");

        // Single request in the first cycle after release, 3*7 -> 21 in C3 only.
        reset_n = 1'b1;
        apply("c0", 1, 32'd3, 32'd7, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step("c1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("c1.src1", bus.A_mul_src1, 32'd3);
        check("c1.src2", bus.A_mul_src2, 32'd7);
        step("c2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("c3", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd21, 0, 0);
        step("c4", 0, 0, 0, 1, 32'd5, 32'd6, 0, 1, 0, 0, 0, 0);

        // Conflict window: both valid for four cycles after requester 1 was last granted.
        step("c5", 1, 32'd11, 32'd3, 1, 32'd21, 32'd3, 1, 0, 0, 0, 0, 0);
`ifdef MULT_ARB_FIXED_PRIO_EN
        step("c6", 1, 32'd12, 32'd3, 1, 32'd22, 32'd3, 1, 0, 0, 0, 0, 0);
        step("c7", 1, 32'd13, 32'd3, 1, 32'd23, 32'd3, 1, 0, 0, 0, 1, 32'd30);
        step("c8", 1, 32'd14, 32'd3, 1, 32'd24, 32'd3, 1, 0, 1, 32'd33, 0, 0);
        step("c9", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd36, 0, 0);
        step("c10", 1, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 1, 0, 1, 32'd39, 0, 0);
        step("c11", 0, 0, 0, 1, 32'h0001_0000, 32'h0001_0000, 0, 1, 1, 32'd42, 0, 0);
`else
        step("c6", 1, 32'd12, 32'd3, 1, 32'd22, 32'd3, 0, 1, 0, 0, 0, 0);
        step("c7", 1, 32'd13, 32'd3, 1, 32'd23, 32'd3, 1, 0, 0, 0, 1, 32'd30);
        step("c8", 1, 32'd14, 32'd3, 1, 32'd24, 32'd3, 0, 1, 1, 32'd33, 0, 0);
        step("c9", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd66);
        step("c10", 1, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 1, 0, 1, 32'd39, 0, 0);
        step("c11", 0, 0, 0, 1, 32'h0001_0000, 32'h0001_0000, 0, 1, 0, 0, 1, 32'd72);
`endif
        // Wrap-around products.
        step("c12", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("c13", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 0, 0);
        step("c14", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0000);
        step("c15", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("c15.hold0", bus.resp0_result, 32'hFFFF_FFFE);

        // Reset in the cycle after a grant: the 9*9 op must never respond.
        step("c16", 1, 32'd9, 32'd9, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        drive(1'b1, 32'd9, 32'd9, 1'b1, 32'd8, 32'd8);
        #1;
        check_reset_outputs("c17");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        // Pointer back at requester 1, so requester 0 wins this conflict.
        apply("c18", 1, 32'd4, 32'd4, 1, 32'd5, 32'd5, 1, 0, 0, 0, 0, 0);
        step("c19", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("c20", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("c21", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd16, 0, 0);
        step("c22", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Latency 3: back-to-back requester-1 products land in E5, E6, E7.
        step3("e0", 1, 32'd2, 32'd2, 1, 0, 0);
        step3("e1", 1, 32'd3, 32'd3, 1, 0, 0);
        step3("e2", 1, 32'd4, 32'd4, 1, 0, 0);
        step3("e3", 0, 0, 0, 0, 0, 0);
        step3("e4", 0, 0, 0, 0, 0, 0);
        step3("e5", 0, 0, 0, 0, 1, 32'd4);
        step3("e6", 0, 0, 0, 0, 1, 32'd9);
        step3("e7", 0, 0, 0, 0, 1, 32'd16);
        step3("e8", 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/final2_soc_nios2_qsys_0_mult_arbiter.md
FINAL2_SOC_NIOS2_QSYS_0_MULT_ARBITER -- requirements
Module: final2_soc_nios2_qsys_0_mult_arbiter

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 1, meaning the cell's input-to-result register latency in cycles; the legal range is 1..4.
REQ-002 SHALL have the following port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have the following port: reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have the following ports: req0_valid  in  1; req0_ready  out  1; req0_a  in  32; req0_b  in  32. These carry requester 0's operand handshake.
REQ-005 SHALL have the following ports: req1_valid  in  1; req1_ready  out  1; req1_a  in  32; req1_b  in  32. These carry requester 1's operand handshake.
REQ-006 SHALL have the following ports: resp0_valid  out  1; resp0_result  out  32. These carry requester 0's product (low 32 bits) and have no backpressure.
REQ-007 SHALL have the following ports: resp1_valid  out  1; resp1_result  out  32. These are the same as REQ-006 for requester 1.
REQ-008 SHALL have the following ports: A_mul_src1  out  32; A_mul_src2  out  32; A_mul_cell_result  in  32. These connect to the shared multiply cell.

Function
REQ-009 SHALL accept at most one request per cycle; a transfer occurs when reqN_valid and reqN_ready are both high in the same cycle.
REQ-010 SHALL drive reqN_ready combinationally from the arbitration result only; ready is high for exactly the granted requester, and only when it is valid.
REQ-011 SHALL grant round-robin: on a conflict, the requester not granted most recently wins; the last-grant pointer resets to requester 1, so requester 0 wins the first conflict.
REQ-012 SHALL grant the sole valid requester in the same cycle when only one is valid, with no bubble.
REQ-013 SHALL register the granted operands onto A_mul_src1/A_mul_src2 at the end of the transfer cycle N, and hold them until the next transfer.
REQ-014 SHALL carry a 2-state tag (valid, owner) through a shift pipeline of depth MUL_LATENCY+1 aligned with the cell.
REQ-015 SHALL sample A_mul_cell_result in cycle N+1+MUL_LATENCY into the owner's resp register.
REQ-016 SHALL pulse respN_valid high for exactly one cycle, in cycle N+2+MUL_LATENCY.
REQ-017 SHALL hold respN_result from the last response until the owner's next response; the value is a don't-care before the first response.
REQ-018 SHALL allow back-to-back transfers every cycle, giving full throughput, with responses delivered strictly in grant order per requester and globally.
REQ-019 SHALL treat the result as an unsigned modulo-2^32 product; no sign handling and no overflow flag.
REQ-020 SHALL never assert resp0_valid and resp1_valid in the same cycle.

Reset
REQ-021 SHALL, on reset_n low, immediately clear: reqN_ready=0, respN_valid=0, respN_result=0, A_mul_src1=A_mul_src2=0, all tag stages invalid, last-grant pointer=1.
REQ-022 SHALL drop in-flight operations when reset is asserted mid-operation; no response is issued for them after release.
REQ-023 SHALL make the first transfer possible in the first cycle after reset_n deasserts.

Configuration
REQ-024 SHALL, when macro MULT_ARB_FIXED_PRIO_EN is defined, use fixed priority with requester 0 always winning conflicts; in that mode the last-grant pointer is omitted.
REQ-025 SHALL use the round-robin arbitration of REQ-011 when MULT_ARB_FIXED_PRIO_EN is not defined.

Verification
REQ-026 SHALL cover single request: req0 a=3,b=7 alone at cycle N, MUL_LATENCY=1 -> req0_ready=1 in N; resp0_valid=1 with resp0_result=21 in N+3 only.
REQ-027 SHALL cover conflict: both valid continuously, 4 cycles, round-robin -> grants 0,1,0,1; responses alternate resp0/resp1 starting N+3, one per cycle.
REQ-028 SHALL cover wrap-around: a=0xFFFFFFFF, b=2 -> respN_result=0xFFFFFFFE; a=0x10000, b=0x10000 -> 0x00000000.
REQ-029 SHALL cover reset mid-operation: grant at N, reset_n low in N+1 for one cycle -> no respN_valid ever for that op; all outputs 0 during reset.
REQ-030 SHALL cover latency parameter: MUL_LATENCY=3, back-to-back req1 products 2*2, 3*3, 4*4 -> resp1_valid in N+5, N+6, N+7 with 4, 9, 16.
REQ-031 SHALL cover fixed priority: with MULT_ARB_FIXED_PRIO_EN defined and both valid 3 cycles -> grants 0,0,0; req1_ready stays 0.
